// File: rtl/ss_pkg.sv
// Shared types and constants for the save-state engine.
// No logic; imported by the engine.
// Not applicable.
package ss_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SAVE,
        RST_IDX,
        RST_VERIFY,
        RST_WRITE,
        FINISH
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_IDX  = 2'd1;
    localparam logic [1:0] ERR_SUM  = 2'd2;

    localparam int DEF_IDX_ADDR = 127;

endpackage

// File: rtl/ss_sum8.sv
// 8-bit modulo-256 accumulator for the save-state checksum.
// Sum updates one cycle after add_en; clear has priority over add.
// No backpressure; accepts one byte per enabled cycle.
module ss_sum8 (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       add_en,
    input  logic [7:0] dat,
    output logic [7:0] sum
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sum <= 8'd0;
        end else if (add_en) begin
            sum <= sum + dat;
        end
    end

endmodule

// File: rtl/ss_engine.sv
// Save/restore sequencer between mapper registers and a byte buffer; SS_CHECKSUM_EN adds a checksum slot.
// Save: one slot per cycle then FINISH; restore: 2-cycle index check, optional verify pass, pipelined writes.
// No backpressure; starts are ignored while busy, outputs forced idle while rst is high.
module ss_engine
    import ss_pkg::*;
#(
    parameter int REG_COUNT = 17,
    parameter int IDX_ADDR  = DEF_IDX_ADDR
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_save,
    input  logic       start_restore,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code,
    output logic       ss_act,
    output logic       ss_we,
    output logic [7:0] ss_addr,
    output logic [7:0] ss_wdat,
    input  logic [7:0] ss_rdat,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdat,
    output logic       mem_we,
    input  logic [7:0] mem_rdat
);

    generate
        if (REG_COUNT < 1 || REG_COUNT + 2 > 256 || IDX_ADDR < REG_COUNT || IDX_ADDR > 255) begin : g_bad_cfg
            $error("ss_engine: REG_COUNT/IDX_ADDR out of range");
        end
    endgenerate

    localparam logic [7:0] RC_B  = 8'(REG_COUNT);
    localparam logic [7:0] IDX_B = 8'(IDX_ADDR);

    state_t     state, nstate;
    logic [7:0] cnt, cnt_nxt;
    logic       fail, fail_nxt;
    logic [1:0] code_q, code_nxt;

    logic       ss_we_c, mem_we_c;
    logic [7:0] ss_addr_c, ss_wdat_c, mem_addr_c, mem_wdat_c;

`ifdef SS_CHECKSUM_EN
    localparam logic [7:0] LAST_B = 8'(REG_COUNT + 1);

    logic       tail, tail_nxt;
    logic       sum_clr, sum_add;
    logic [7:0] sum_dat, sum;

    ss_sum8 u_sum (
        .clk    (clk),
        .rst    (rst),
        .clr    (sum_clr),
        .add_en (sum_add),
        .dat    (sum_dat),
        .sum    (sum)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= 8'd0;
            fail   <= 1'b0;
            code_q <= ERR_NONE;
`ifdef SS_CHECKSUM_EN
            tail   <= 1'b0;
`endif
        end else begin
            state  <= nstate;
            cnt    <= cnt_nxt;
            fail   <= fail_nxt;
            code_q <= code_nxt;
`ifdef SS_CHECKSUM_EN
            tail   <= tail_nxt;
`endif
        end
    end

    always_comb begin
        nstate     = state;
        cnt_nxt    = cnt;
        fail_nxt   = fail;
        code_nxt   = code_q;
        ss_we_c    = 1'b0;
        ss_addr_c  = 8'd0;
        ss_wdat_c  = 8'd0;
        mem_we_c   = 1'b0;
        mem_addr_c = 8'd0;
        mem_wdat_c = 8'd0;
`ifdef SS_CHECKSUM_EN
        tail_nxt   = tail;
        sum_clr    = 1'b0;
        sum_add    = 1'b0;
        sum_dat    = 8'd0;
`endif
        case (state)
            IDLE: begin
                if (start_save || start_restore) begin
                    nstate   = start_save ? SAVE : RST_IDX;
                    cnt_nxt  = 8'd0;
                    fail_nxt = 1'b0;
                    code_nxt = ERR_NONE;
`ifdef SS_CHECKSUM_EN
                    sum_clr  = 1'b1;
                    tail_nxt = 1'b0;
`endif
                end
            end
            SAVE: begin
                // slot 0 carries the index byte, slot k+1 carries register k
                mem_we_c   = 1'b1;
                mem_addr_c = cnt;
                ss_addr_c  = (cnt == 8'd0) ? IDX_B : cnt - 8'd1;
                mem_wdat_c = ss_rdat;
`ifdef SS_CHECKSUM_EN
                sum_add = 1'b1;
                sum_dat = ss_rdat;
                if (cnt == LAST_B) begin
                    mem_wdat_c = sum;
                    sum_add    = 1'b0;
                    nstate     = FINISH;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
`else
                if (cnt == RC_B) begin
                    nstate = FINISH;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
`endif
            end
            RST_IDX: begin
                mem_addr_c = 8'd0;
                ss_addr_c  = IDX_B;
                if (cnt == 8'd0) begin
                    cnt_nxt = 8'd1;
                end else if (mem_rdat != ss_rdat) begin
                    fail_nxt = 1'b1;
                    code_nxt = ERR_IDX;
                    nstate   = FINISH;
                end else begin
                    cnt_nxt = 8'd0;
`ifdef SS_CHECKSUM_EN
                    nstate  = RST_VERIFY;
`else
                    nstate  = RST_WRITE;
`endif
                end
            end
`ifdef SS_CHECKSUM_EN
            RST_VERIFY: begin
                // read data lags the address by one cycle; tail marks the final
                // compare cycle so the counter never has to pass REG_COUNT+1
                mem_addr_c = cnt;
                if (!tail) begin
                    sum_add = (cnt != 8'd0);
                    sum_dat = mem_rdat;
                    if (cnt == LAST_B) begin
                        tail_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 8'd1;
                    end
                end else if (mem_rdat != sum) begin
                    fail_nxt = 1'b1;
                    code_nxt = ERR_SUM;
                    nstate   = FINISH;
                end else begin
                    cnt_nxt = 8'd0;
                    nstate  = RST_WRITE;
                end
            end
`endif
            RST_WRITE: begin
                // cycle c fetches slot c+1 and writes register c-1 from the previous fetch
                if (cnt != RC_B) begin
                    mem_addr_c = cnt + 8'd1;
                end
                if (cnt != 8'd0) begin
                    ss_we_c   = 1'b1;
                    ss_addr_c = cnt - 8'd1;
                    ss_wdat_c = mem_rdat;
                end
                if (cnt == RC_B) begin
                    nstate = FINISH;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            FINISH: begin
                nstate = IDLE;
            end
            default: begin
                nstate = IDLE;
            end
        endcase
    end

    assign busy     = !rst && (state != IDLE);
    assign ss_act   = busy;
    assign done     = !rst && (state == FINISH) && !fail;
    assign err      = !rst && (state == FINISH) && fail;
    assign err_code = rst ? ERR_NONE : code_q;
    assign ss_we    = !rst && ss_we_c;
    assign ss_addr  = rst ? 8'd0 : ss_addr_c;
    assign ss_wdat  = rst ? 8'd0 : ss_wdat_c;
    assign mem_we   = !rst && mem_we_c;
    assign mem_addr = rst ? 8'd0 : mem_addr_c;
    assign mem_wdat = rst ? 8'd0 : mem_wdat_c;

endmodule

// File: tb/tb_ss_engine.sv
// Self-checking bench for ss_engine: vector table, hand sequences, randomized save/restore vs a buffer-image model.
module tb_ss_engine;

    localparam int RC  = 17;
    localparam int IDX = 127;
`ifdef SS_CHECKSUM_EN
    localparam bit CS = 1'b1;
`else
    localparam bit CS = 1'b0;
`endif
    localparam int NS  = RC + 1 + int'(CS);
    localparam int LIM = 3000;

    logic       clk, rst, start_save, start_restore;
    logic       busy, done, err, ss_act, ss_we, mem_we;
    logic [1:0] err_code;
    logic [7:0] ss_addr, ss_wdat, ss_rdat, mem_addr, mem_wdat, mem_rdat;

    logic [7:0] mreg    [256];
    logic [7:0] mem     [256];
    logic [7:0] pre_img [256];
    bit         pre_ld;
    logic [7:0] wlog_a [$];
    logic [7:0] wlog_d [$];
    int         idx_hits = 0;
    int         mwe_n    = 0;
    int         total    = 0;
    int         bad      = 0;

    ss_engine #(.REG_COUNT(RC), .IDX_ADDR(IDX)) dut (
        .clk           (clk),
        .rst           (rst),
        .start_save    (start_save),
        .start_restore (start_restore),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .err_code      (err_code),
        .ss_act        (ss_act),
        .ss_we         (ss_we),
        .ss_addr       (ss_addr),
        .ss_wdat       (ss_wdat),
        .ss_rdat       (ss_rdat),
        .mem_addr      (mem_addr),
        .mem_wdat      (mem_wdat),
        .mem_we        (mem_we),
        .mem_rdat      (mem_rdat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign ss_rdat = mreg[ss_addr];

    // buffer with one-cycle read latency, plus a log of every mapper write
    always @(posedge clk) begin
        if (pre_ld) begin
            for (int i = 0; i < 256; i++) mem[i] <= pre_img[i];
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdat;
        end
        mem_rdat <= mem[mem_addr];
        if (ss_we) begin
            wlog_a.push_back(ss_addr);
            wlog_d.push_back(ss_wdat);
            if (ss_addr == 8'(IDX)) idx_hits <= idx_hits + 1;
        end
        if (mem_we) mwe_n <= mwe_n + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    function automatic logic [7:0] img_sum(input int n);
        logic [7:0] s = 8'd0;
        for (int i = 0; i < n; i++) s = s + pre_img[i];
        return s;
    endfunction

    function automatic void fix_cs();
        if (CS) pre_img[RC + 1] = img_sum(RC + 1);
    endfunction

    // expected restore outcome straight from the buffer image and mapper index
    function automatic int model_code();
        if (pre_img[0] != mreg[IDX]) return 1;
        if (CS && img_sum(RC + 1) != pre_img[RC + 1]) return 2;
        return 0;
    endfunction

    function automatic int save_mism();
        logic [7:0] exp_img [RC + 2];
        logic [7:0] s = 8'd0;
        int m = 0;
        exp_img[0] = mreg[IDX];
        for (int k = 0; k < RC; k++) exp_img[k + 1] = mreg[k];
        for (int i = 0; i <= RC; i++) s = s + exp_img[i];
        exp_img[RC + 1] = s;
        for (int i = 0; i < NS; i++) if (mem[i] !== exp_img[i]) m++;
        return m;
    endfunction

    function automatic int write_mism(input int base);
        int m = 0;
        for (int i = 0; i < RC; i++) begin
            if (base + i >= wlog_a.size()) m++;
            else if (wlog_a[base + i] != 8'(i) || wlog_d[base + i] != pre_img[i + 1]) m++;
        end
        return m;
    endfunction

    task automatic load_buf();
        @(negedge clk);
        pre_ld = 1'b1;
        @(negedge clk);
        pre_ld = 1'b0;
    endtask

    task automatic pattern_regs();
        for (int k = 0; k < RC; k++) mreg[k] = 8'(8'h10 + k);
        mreg[IDX] = 8'hC7;
    endtask

    task automatic pattern_img();
        pre_img[0] = 8'hC7;
        for (int k = 0; k < RC; k++) pre_img[k + 1] = 8'(8'hA0 + k);
        fix_cs();
    endtask

    task automatic launch(input bit sv, input bit rs, output int lat, output bit gd,
                          output bit ge, output logic [1:0] gc);
        @(negedge clk);
        start_save    = sv;
        start_restore = rs;
        @(negedge clk);
        start_save    = 1'b0;
        start_restore = 1'b0;
        lat = 1;
        while (!done && !err && lat < LIM) begin
            @(negedge clk);
            lat++;
        end
        gd = done;
        ge = err;
        gc = err_code;
        if (!gd && !ge) begin
            total++;
            bad++;
            $display("FAIL timeout: no done/err within %0d cycles", LIM);
        end
        @(negedge clk);
    endtask

    typedef struct {
        bit         sv;
        bit         rs;
        int         corrupt;
        bit         exp_done;
        logic [1:0] exp_code;
        int         exp_we;
        int         exp_mwe;
    } vec_t;

    vec_t       tbl [5];
    int         lat, wb, mb, ec, n, mode;
    bit         gd, ge;
    logic [1:0] gc;

    initial begin
        rst = 1'b1;
        start_save = 1'b1;
        start_restore = 1'b1;
        pre_ld = 1'b0;
        for (int i = 0; i < 256; i++) begin
            pre_img[i] = 8'd0;
            mreg[i] = 8'd0;
        end
        pre_ld = 1'b1;
        repeat (3) @(negedge clk);
        pre_ld = 1'b0;

        check("rst_ctrl", int'({busy, done, err, ss_act, ss_we, mem_we}), 0);
        check("rst_err_code", int'(err_code), 0);
        check("rst_ss_addr", int'(ss_addr), 0);
        check("rst_ss_wdat", int'(ss_wdat), 0);
        check("rst_mem_addr", int'(mem_addr), 0);
        start_save = 1'b0;
        start_restore = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", int'(busy), 0);

        tbl[0] = '{1'b1, 1'b0, -1, 1'b1, 2'd0, 0, NS};
        tbl[1] = '{1'b0, 1'b1, -1, 1'b1, 2'd0, RC, 0};
        tbl[2] = '{1'b0, 1'b1, 0, 1'b0, 2'd1, 0, 0};
        if (CS) tbl[3] = '{1'b0, 1'b1, 5, 1'b0, 2'd2, 0, 0};
        else    tbl[3] = '{1'b0, 1'b1, 5, 1'b1, 2'd0, RC, 0};
        tbl[4] = '{1'b1, 1'b1, -1, 1'b1, 2'd0, 0, NS};

        for (int i = 0; i < 5; i++) begin
            pattern_regs();
            pattern_img();
            if (tbl[i].corrupt >= 0) pre_img[tbl[i].corrupt] = pre_img[tbl[i].corrupt] ^ 8'h5A;
            load_buf();
            wb = wlog_a.size();
            mb = mwe_n;
            launch(tbl[i].sv, tbl[i].rs, lat, gd, ge, gc);
            check($sformatf("tbl%0d_done", i), int'(gd), int'(tbl[i].exp_done));
            check($sformatf("tbl%0d_err", i), int'(ge), int'(!tbl[i].exp_done));
            check($sformatf("tbl%0d_code", i), int'(gc), int'(tbl[i].exp_code));
            check($sformatf("tbl%0d_we", i), wlog_a.size() - wb, tbl[i].exp_we);
            check($sformatf("tbl%0d_mwe", i), mwe_n - mb, tbl[i].exp_mwe);
            if (tbl[i].sv) begin
                check($sformatf("tbl%0d_lat", i), lat, NS + 1);
                check($sformatf("tbl%0d_img", i), save_mism(), 0);
            end else if (tbl[i].exp_done) begin
                check($sformatf("tbl%0d_wdat", i), write_mism(wb), 0);
            end
        end

        // error code holds after an aborted restore and clears on the next start
        pattern_regs();
        pattern_img();
        pre_img[0] = 8'h12;
        load_buf();
        wb = wlog_a.size();
        launch(1'b0, 1'b1, lat, gd, ge, gc);
        check("badidx_err", int'(ge), 1);
        check("badidx_we", wlog_a.size() - wb, 0);
        repeat (3) @(negedge clk);
        check("errcode_hold", int'(err_code), 1);
        start_save = 1'b1;
        @(negedge clk);
        start_save = 1'b0;
        check("errcode_clr", int'(err_code), 0);
        check("busy_on_start", int'(ss_act), 1);
        n = 0;
        while (!done && n < LIM) begin
            @(negedge clk);
            n++;
        end
        check("errcode_save_done", int'(done), 1);
        @(negedge clk);

        // restore request in the middle of a save is dropped
        pattern_regs();
        wb = wlog_a.size();
        mb = mwe_n;
        start_save = 1'b1;
        @(negedge clk);
        start_save = 1'b0;
        repeat (4) @(negedge clk);
        start_restore = 1'b1;
        @(negedge clk);
        start_restore = 1'b0;
        n = 0;
        while (!done && n < LIM) begin
            @(negedge clk);
            n++;
        end
        check("midsave_done", int'(done), 1);
        repeat (2) @(negedge clk);
        check("midsave_idle", int'(busy), 0);
        check("midsave_we", wlog_a.size() - wb, 0);
        check("midsave_mwe", mwe_n - mb, NS);

        // reset during the fifth RST_WRITE cycle
        pattern_regs();
        pattern_img();
        load_buf();
        wb = wlog_a.size();
        start_restore = 1'b1;
        @(negedge clk);
        start_restore = 1'b0;
        n = 0;
        while (!ss_we && n < LIM) begin
            @(negedge clk);
            n++;
        end
        check("rstmid_we_seen", int'(ss_we), 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        mb = wlog_a.size();
        check("rstmid_prior_we", mb - wb, 3);
        @(negedge clk);
        check("rstmid_busy", int'(busy), 0);
        check("rstmid_act", int'(ss_act), 0);
        rst = 1'b0;
        repeat (RC + 5) @(negedge clk);
        check("rstmid_no_we", wlog_a.size() - mb, 0);
        check("rstmid_idle", int'(busy), 0);
        for (int k = 0; k < RC; k++) mreg[k] = 8'($urandom);
        launch(1'b1, 1'b0, lat, gd, ge, gc);
        check("rstmid_save_done", int'(gd), 1);
        check("rstmid_save_img", save_mism(), 0);

        for (int it = 0; it < 24; it++) begin
            for (int k = 0; k < RC; k++) mreg[k] = 8'($urandom);
            mreg[IDX] = 8'($urandom);
            mode = $urandom_range(0, 3);
            if (mode == 0) begin
                mb = mwe_n;
                launch(1'b1, 1'b0, lat, gd, ge, gc);
                check($sformatf("rnd%0d_sv_done", it), int'(gd), 1);
                check($sformatf("rnd%0d_sv_img", it), save_mism(), 0);
                check($sformatf("rnd%0d_sv_mwe", it), mwe_n - mb, NS);
            end else begin
                pre_img[0] = (mode == 1) ? 8'($urandom) : mreg[IDX];
                for (int k = 0; k < RC; k++) pre_img[k + 1] = 8'($urandom);
                fix_cs();
                if (mode == 3) begin
                    n = $urandom_range(1, RC);
                    pre_img[n] = pre_img[n] ^ (8'd1 << $urandom_range(0, 7));
                end
                ec = model_code();
                load_buf();
                wb = wlog_a.size();
                launch(1'b0, 1'b1, lat, gd, ge, gc);
                check($sformatf("rnd%0d_rs_code", it), int'(gc), ec);
                check($sformatf("rnd%0d_rs_done", it), int'(gd), int'(ec == 0));
                check($sformatf("rnd%0d_rs_we", it), wlog_a.size() - wb, (ec == 0) ? RC : 0);
                if (ec == 0) check($sformatf("rnd%0d_rs_wdat", it), write_mism(wb), 0);
            end
        end

        check("idx_never_written", idx_hits, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
